mem_block_copy_master: RTL and testbench
========================================

Name: mem_block_copy_master

Overview:
Avalon-MM master that copies a block of 32-bit words from one region of an on-chip data memory slave to another region of the same slave. It is the initiator side of the data-memory slave interface: it drives address/byteenable/chipselect/write/writedata and samples readdata. The JPEG MPSoC uses it to move tiles and coefficient buffers between memory regions without CPU load. A simple start/busy/done command port controls it.

Parameters:
ADDR_W, 11, word-address width of the memory slave (2048 words)
DATA_W, 32, data width; byteenable width is DATA_W/8
LEN_W, 12, width of the length field; must hold 2**ADDR_W

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  command strobe; sampled only while idle
src_addr  in  ADDR_W  first source word address
dst_addr  in  ADDR_W  first destination word address
length  in  LEN_W  number of words to copy
busy  out  1  copy in progress
done  out  1  one-cycle pulse when the command completes
words_copied  out  LEN_W  count of completed writes in the current or last command
av_address  out  ADDR_W  master word address
av_byteenable  out  DATA_W/8  always all-ones while chipselect=1
av_chipselect  out  1  transfer request
av_write  out  1  1 = write, 0 = read (valid with chipselect)
av_writedata  out  DATA_W  write data
av_readdata  in  DATA_W  read data; valid exactly 1 cycle after an accepted read
av_waitrequest  in  1  slave stall; a transfer is accepted on a cycle with chipselect=1 and waitrequest=0
av_clken  out  1  memory clock enable; held at 1 except during reset

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE. All outputs 0: busy, done, chipselect, write, address, byteenable, writedata, words_copied, clken.
- FSM states: IDLE, RD, RD_DATA, WR, FIN.
- IDLE: on start=1, latch src_ptr=src_addr, dst_ptr=dst_addr, remaining=min(length, 2**ADDR_W), and clear words_copied. If the clamped length is 0, go to FIN. Otherwise go to RD. start while not IDLE is ignored; no queueing.
- RD: chipselect=1, write=0, address=src_ptr. Hold all signals while waitrequest=1. On accept, go to RD_DATA.
- RD_DATA: chipselect=0. Capture av_readdata into the data register, then go to WR.
- WR: chipselect=1, write=1, byteenable=all-ones, address=dst_ptr, writedata=data register. Hold while waitrequest=1. On accept:
  - src_ptr++ and dst_ptr++, both modulo 2**ADDR_W, so addresses wrap from 2047 to 0.
  - remaining--, words_copied++.
  - If remaining was 1, go to FIN; else go to RD.
- FIN: done=1 for exactly one cycle, then IDLE.
- busy=1 in RD, RD_DATA and WR; 0 in IDLE and FIN.
- Timing: start sampled at edge k gives busy=1 and the first read presented from cycle k+1. With no stalls each word takes 3 cycles, and done pulses in cycle k+1+3N. For length 0, done pulses in cycle k+1 and busy never rises.
- Every waitrequest stall cycle adds exactly one cycle to the word in progress.
- Overlapping regions: strictly ascending word-by-word read-then-write. With dst > src and overlap, the copy propagates data forward; this is defined behaviour, not an error.
- words_copied holds its final value after done until the next accepted start.
- reset_n asserted mid-copy aborts immediately to reset values, with no done pulse. Memory contents already written are not restored.

Test Plan:
- Basic copy: preload mem[0..3]=0x11,0x22,0x33,0x44; start with src=0, dst=100, len=4, no waitrequest → mem[100..103] match, done at cycle k+13, words_copied=4.
- Zero length: len=0 → done at k+1, no chipselect, busy stays 0.
- Stalls: same as basic copy, with waitrequest=1 for 2 cycles on each read and each write → data correct, done at k+13+16, signals held stable during stalls.
- Wrap and clamp: src=2046, dst=10, len=3 → reads 2046, 2047, 0. Separately, len=4000 → exactly 2048 writes.
- Start while busy: pulse start mid-copy with other args → ignored, original copy completes unchanged.
- Reset mid-copy: assert reset_n=0 after 2 words → all outputs 0 at once, no done; a new start afterwards completes normally.

Source files
------------

// File: rtl/mem_block_copy_master_if.sv
// ============================================================================
//  Module   : mem_block_copy_master_if
//  Brief    : Avalon-MM data-memory port between the block-copy master and the slave.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_block_copy_master_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   av_address;
    logic [DATA_W/8-1:0] av_byteenable;
    logic                av_chipselect;
    logic                av_write;
    logic [DATA_W-1:0]   av_writedata;
    logic [DATA_W-1:0]   av_readdata;
    logic                av_waitrequest;
    logic                av_clken;

    modport master (
        output av_address, av_byteenable, av_chipselect, av_write, av_writedata, av_clken,
        input  av_readdata, av_waitrequest
    );

    modport slave (
        input  av_address, av_byteenable, av_chipselect, av_write, av_writedata, av_clken,
        output av_readdata, av_waitrequest
    );
endinterface

`default_nettype wire

// File: rtl/mem_block_copy_master.sv
// ============================================================================
//  Module   : mem_block_copy_master
//  Brief    : Avalon-MM master copying a block of words between memory regions.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mem_block_copy_master #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 12
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] src_addr,
    input  wire logic [ADDR_W-1:0] dst_addr,
    input  wire logic [LEN_W-1:0]  length,
    output logic                   busy,
    output logic                   done,
    output logic [LEN_W-1:0]       words_copied,
    mem_block_copy_master_if.master av
);

    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR      = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                clken_q;
    logic [LEN_W-1:0]    w_len_clamped;
    logic                w_cs;
    logic                w_wr;

    assign w_len_clamped = (length > c_max_len) ? c_max_len : length;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            clken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            clken_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        w_cs    = 1'b0;
        w_wr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = w_len_clamped;
                    cnt_d   = '0;
                    state_d = (w_len_clamped == '0) ? S_FIN : S_RD;
                end
            end
            S_RD: begin
                w_cs = 1'b1;
                if (!av.av_waitrequest) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                // Slave returns read data exactly one cycle after acceptance.
                data_d  = av.av_readdata;
                state_d = S_WR;
            end
            S_WR: begin
                w_cs = 1'b1;
                w_wr = 1'b1;
                if (!av.av_waitrequest) begin
                    src_d   = src_q + 1'b1;
                    dst_d   = dst_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (rem_q == LEN_W'(1)) ? S_FIN : S_RD;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign av.av_chipselect = w_cs;
    assign av.av_write      = w_wr;
    assign av.av_address    = (state_q == S_WR) ? dst_q :
                              (state_q == S_RD) ? src_q : '0;
    assign av.av_byteenable = w_cs ? '1 : '0;
    assign av.av_writedata  = data_q;
    assign av.av_clken      = clken_q;

    assign busy         = (state_q == S_RD) || (state_q == S_RD_DATA) || (state_q == S_WR);
    assign done         = (state_q == S_FIN);
    assign words_copied = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_block_copy_master.sv
// ============================================================================
//  Module   : tb_mem_block_copy_master
//  Brief    : Self-checking bench with a memory slave and write/read scoreboard.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_block_copy_master;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 12;
    localparam int DEPTH  = 2048;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  words_copied;

    mem_block_copy_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_block_copy_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .words_copied (words_copied),
        .av           (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata = '0;
    int                stall_n = 0;
    int                stall_cnt = 0;
    bit                cs_seen;
    bit                busy_seen;
    wr_t               exp_wr_q[$];
    logic [ADDR_W-1:0] exp_rd_q[$];

    assign bus.av_waitrequest = bus.av_chipselect && (stall_cnt < stall_n);
    assign bus.av_readdata    = rdata;

    // Memory slave: stalls each transfer stall_n cycles, read data one cycle later.
    initial begin
        forever begin
            @(posedge clk);
            if (bus.av_chipselect && reset_n) begin
                if (bus.av_waitrequest) begin
                    stall_cnt <= stall_cnt + 1;
                end else begin
                    stall_cnt <= 0;
                    if (bus.av_write) mem[bus.av_address] = bus.av_writedata;
                    else              rdata <= mem[bus.av_address];
                end
            end else begin
                stall_cnt <= 0;
            end
        end
    end

    // Bus monitor: scoreboard pops on accepted transfers, stall-hold checks.
    initial begin
        bit                prev_stall;
        logic [ADDR_W-1:0] prev_addr;
        logic              prev_wr;
        logic [DATA_W-1:0] prev_wd;
        wr_t               e;
        logic [ADDR_W-1:0] ra;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
            if (reset_n && bus.av_chipselect) begin
                cs_seen = 1'b1;
                if (prev_stall) begin
                    checks++;
                    if (bus.av_address !== prev_addr || bus.av_write !== prev_wr ||
                        (prev_wr && bus.av_writedata !== prev_wd)) begin
                        errors++;
                        $display("FAIL stall_hold: got addr %0h wr %0b wd %0h, required addr %0h wr %0b wd %0h",
                                 bus.av_address, bus.av_write, bus.av_writedata, prev_addr, prev_wr, prev_wd);
                    end
                end
                if (!bus.av_waitrequest) begin
                    checks++;
                    if (bus.av_byteenable !== 4'hF) begin
                        errors++;
                        $display("FAIL byteenable: got %0h required f", bus.av_byteenable);
                    end
                    if (bus.av_write) begin
                        if (exp_wr_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_write: got addr %0h data %0h, required none",
                                     bus.av_address, bus.av_writedata);
                        end else begin
                            e = exp_wr_q.pop_front();
                            if (bus.av_address !== e.addr || bus.av_writedata !== e.data) begin
                                errors++;
                                $display("FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                                         bus.av_address, bus.av_writedata, e.addr, e.data);
                            end
                        end
                    end else begin
                        if (exp_rd_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_read: got addr %0h, required none", bus.av_address);
                        end else begin
                            ra = exp_rd_q.pop_front();
                            if (bus.av_address !== ra) begin
                                errors++;
                                $display("FAIL read_addr: got %0h required %0h", bus.av_address, ra);
                            end
                        end
                    end
                end
                prev_stall = bus.av_waitrequest;
                prev_addr  = bus.av_address;
                prev_wr    = bus.av_write;
                prev_wd    = bus.av_writedata;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Sequential reference copy from the current memory image into the scoreboard.
    task automatic push_expect(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                               input int n);
        logic [DATA_W-1:0] m [DEPTH];
        logic [ADDR_W-1:0] a, b;
        wr_t               e;
        m = mem;
        for (int i = 0; i < n; i++) begin
            a = ADDR_W'(int'(s) + i);
            b = ADDR_W'(int'(d) + i);
            exp_rd_q.push_back(a);
            e.addr = b;
            e.data = m[a];
            exp_wr_q.push_back(e);
            m[b] = m[a];
        end
    endtask

    task automatic run_cmd(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                           input logic [LEN_W-1:0] len, input int exp_cyc, input bit inject,
                           input string name);
        int n;
        int cyc;
        n = (len > LEN_W'(DEPTH)) ? DEPTH : int'(len);
        push_expect(s, d, n);
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        length    = len;
        start     = 1'b1;
        cs_seen   = 1'b0;
        busy_seen = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        checks++;
        if (busy !== (n != 0)) begin
            errors++;
            $display("FAIL %s_busy_rise: got %0b required %0b", name, busy, (n != 0));
        end
        while (!done && cyc < exp_cyc + 50) begin
            if (inject && cyc == 4) begin
                src_addr = 11'd700;
                dst_addr = 11'd900;
                length   = 12'd9;
                start    = 1'b1;
            end
            if (inject && cyc == 6) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: got no done after %0d cycles, required done at %0d", name, cyc, exp_cyc);
        end else if (cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s_done_cycle: got %0d required %0d", name, cyc, exp_cyc);
        end
        checks++;
        if (busy !== 1'b0 || words_copied !== LEN_W'(n)) begin
            errors++;
            $display("FAIL %s_final: got busy %0b words %0d, required busy 0 words %0d",
                     name, busy, words_copied, n);
        end
        checks++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d writes %0d reads outstanding, required 0",
                     name, exp_wr_q.size(), exp_rd_q.size());
        end
        exp_wr_q.delete();
        exp_rd_q.delete();
        if (n == 0) begin
            checks++;
            if (cs_seen || busy_seen) begin
                errors++;
                $display("FAIL %s_idle_bus: got cs %0b busy %0b, required 0 0", name, cs_seen, busy_seen);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || words_copied !== LEN_W'(n)) begin
            errors++;
            $display("FAIL %s_after_done: got done %0b words %0d, required done 0 words %0d",
                     name, done, words_copied, n);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || words_copied !== '0 || bus.av_chipselect !== 1'b0 ||
            bus.av_write !== 1'b0 || bus.av_address !== '0 || bus.av_byteenable !== '0 ||
            bus.av_writedata !== '0 || bus.av_clken !== 1'b0) begin
            errors++;
            $display("FAIL %s: got busy %0b done %0b wc %0d cs %0b wr %0b a %0h be %0h wd %0h ck %0b, required all 0",
                     name, busy, done, words_copied, bus.av_chipselect, bus.av_write, bus.av_address,
                     bus.av_byteenable, bus.av_writedata, bus.av_clken);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        check_all_zero("reset_outputs");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.av_clken !== 1'b1) begin
            errors++;
            $display("FAIL clken_after_reset: got %0b required 1", bus.av_clken);
        end
    endtask

    task automatic test_basic();
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        run_cmd(11'd0, 11'd100, 12'd4, 13, 1'b0, "basic");
        checks++;
        if (mem[100] !== 32'h11 || mem[101] !== 32'h22 || mem[102] !== 32'h33 || mem[103] !== 32'h44) begin
            errors++;
            $display("FAIL basic_mem: got %0h %0h %0h %0h required 11 22 33 44",
                     mem[100], mem[101], mem[102], mem[103]);
        end
    endtask

    task automatic test_zero_len();
        run_cmd(11'd5, 11'd600, 12'd0, 1, 1'b0, "zero_len");
    endtask

    task automatic test_stalls();
        stall_n = 2;
        run_cmd(11'd0, 11'd200, 12'd4, 29, 1'b0, "stalls");
        stall_n = 0;
    endtask

    task automatic test_wrap_clamp();
        run_cmd(11'd2046, 11'd10, 12'd3, 10, 1'b0, "wrap");
        run_cmd(11'd0, 11'd1024, 12'd4000, 3 * DEPTH + 1, 1'b0, "clamp");
    endtask

    task automatic test_start_busy();
        run_cmd(11'd50, 11'd500, 12'd5, 16, 1'b1, "start_busy");
    endtask

    task automatic test_reset_mid();
        int t;
        push_expect(11'd200, 11'd300, 8);
        @(negedge clk);
        src_addr = 11'd200;
        dst_addr = 11'd300;
        length   = 12'd8;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (words_copied != 12'd2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (words_copied !== 12'd2) begin
            errors++;
            $display("FAIL reset_mid_progress: got %0d words required 2", words_copied);
        end
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid_outputs");
        exp_wr_q.delete();
        exp_rd_q.delete();
        t = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) t++;
        end
        checks++;
        if (t != 0) begin
            errors++;
            $display("FAIL reset_mid_done: got %0d done cycles required 0", t);
        end
        reset_n = 1'b1;
        run_cmd(11'd400, 11'd800, 12'd3, 10, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_cmd(11'd1000, 11'd1500, 12'd2, 7, 1'b0, "b2b_first");
        run_cmd(11'd1500, 11'd1700, 12'd2, 7, 1'b0, "b2b_second");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        test_reset();
        test_basic();
        test_zero_len();
        test_stalls();
        test_wrap_clamp();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
